// File: rtl/store_subword_unit.sv
// Store-side byte/halfword lane placement for a word-only memory port.
// Sub-word stores are done as read-modify-write; word stores skip the read.
module store_subword_unit #(
    parameter int ADDR_WIDTH = 32,
    parameter int BIG_ENDIAN = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [31:0]           req_data,
    input  logic [1:0]            req_size,
    output logic                  done,
    output logic                  err,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_rd,
    output logic                  mem_wr,
    output logic [31:0]           mem_wdata,
    input  logic [31:0]           mem_rdata,
    input  logic                  mem_ack
);

    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

    state_t      state;
    state_t      state_next;
    logic        reject;
    logic        accept;
    logic [1:0]  cap_off;
    logic [15:0] cap_data;
    logic        cap_half;

    // Replace only the addressed lane(s) of the word read back from memory.
    function automatic logic [31:0] merge(input logic [31:0] old, input logic [15:0] data,
                                          input logic half, input logic [1:0] off);
        logic [31:0] word;
        logic [1:0]  lane;
        logic        hsel;
        word = old;
        if (half) begin
            hsel = (BIG_ENDIAN != 0) ? ~off[1] : off[1];
            if (hsel) word[31:16] = data;
            else      word[15:0]  = data;
        end else begin
            lane = (BIG_ENDIAN != 0) ? (2'd3 - off) : off;
            word[8*lane +: 8] = data[7:0];
        end
        return word;
    endfunction

    assign accept = (state == IDLE) && req_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        reject     = 1'b0;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    case (req_size)
                        2'b00: state_next = READ;
                        2'b01: begin
                            if (req_addr[0]) begin
                                state_next = DONE;
                                reject     = 1'b1;
                            end else begin
                                state_next = READ;
                            end
                        end
                        2'b10: begin
                            if (req_addr[1:0] != 2'b00) begin
                                state_next = DONE;
                                reject     = 1'b1;
                            end else begin
                                state_next = WRITE;
                            end
                        end
                        default: begin
                            state_next = DONE;
                            reject     = 1'b1;
                        end
                    endcase
                end
            end
            READ:    if (mem_ack) state_next = WRITE;
            WRITE:   if (mem_ack) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Strobes and handshake outputs are registered copies of the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_ready <= 1'b1;
            done      <= 1'b0;
            err       <= 1'b0;
            mem_rd    <= 1'b0;
            mem_wr    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            cap_off   <= '0;
            cap_data  <= '0;
            cap_half  <= 1'b0;
        end else begin
            req_ready <= (state_next == IDLE);
            mem_rd    <= (state_next == READ);
            mem_wr    <= (state_next == WRITE);
            done      <= (state_next == DONE);
            err       <= reject;
            if (accept) begin
                mem_addr <= {req_addr[ADDR_WIDTH-1:2], 2'b00};
                cap_off  <= req_addr[1:0];
                cap_data <= req_data[15:0];
                cap_half <= req_size[0];
                if (state_next == WRITE) mem_wdata <= req_data;
            end
            if (state == READ && mem_ack)
                mem_wdata <= merge(mem_rdata, cap_data, cap_half, cap_off);
        end
    end

endmodule

// File: tb/tb_store_subword_unit.sv
// Bench for store_subword_unit: little- and big-endian instances share stimulus
// and are compared each cycle against an expected-output timeline.
module tb_store_subword_unit;

    localparam int AW = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req_valid;
    logic [AW-1:0] req_addr;
    logic [31:0]   req_data;
    logic [1:0]    req_size;
    logic          mem_ack;
    logic [31:0]   mem_rdata;

    logic          le_ready, le_done, le_err, le_rd, le_wr;
    logic [AW-1:0] le_addr;
    logic [31:0]   le_wdata;
    logic          be_ready, be_done, be_err, be_rd, be_wr;
    logic [AW-1:0] be_addr;
    logic [31:0]   be_wdata;

    store_subword_unit #(.ADDR_WIDTH(AW), .BIG_ENDIAN(0)) u_le (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(le_ready),
        .req_addr(req_addr), .req_data(req_data), .req_size(req_size),
        .done(le_done), .err(le_err), .mem_addr(le_addr), .mem_rd(le_rd),
        .mem_wr(le_wr), .mem_wdata(le_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    store_subword_unit #(.ADDR_WIDTH(AW), .BIG_ENDIAN(1)) u_be (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(be_ready),
        .req_addr(req_addr), .req_data(req_data), .req_size(req_size),
        .done(be_done), .err(be_err), .mem_addr(be_addr), .mem_rd(be_rd),
        .mem_wr(be_wr), .mem_wdata(be_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        ready;
        logic        rd;
        logic        wr;
        logic        done;
        logic        err;
        logic [31:0] addr;
        logic [31:0] wd_le;
        logic [31:0] wd_be;
    } exp_t;

    exp_t exp_q[$];
    exp_t cmp_e;
    int   n_cmp  = 0;
    int   n_fail = 0;

    task automatic chk1(input string name, input logic act, input logic req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b at %0t", name, act, req, $time);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
        end
    endtask

    // Expected write word straight from the lane rules: byte lane o (LE) or
    // 3-o (BE), half lane h (LE) or 1-h (BE); everything else is old data.
    function automatic logic [31:0] model_merge(input logic [31:0] old, input logic [31:0] data,
                                                input logic [1:0] size, input logic [1:0] off,
                                                input bit be);
        int          lane;
        logic [31:0] mask;
        logic [31:0] ins;
        if (size == 2'b10) return data;
        if (size == 2'b00) begin
            lane = be ? 3 - int'(off) : int'(off);
            mask = 32'hFF << (8 * lane);
            ins  = (data & 32'hFF) << (8 * lane);
        end else begin
            lane = be ? 1 - int'(off[1]) : int'(off[1]);
            mask = 32'hFFFF << (16 * lane);
            ins  = (data & 32'hFFFF) << (16 * lane);
        end
        return (old & ~mask) | ins;
    endfunction

    function automatic exp_t idle_e();
        exp_t e;
        e = '0;
        e.ready = 1'b1;
        return e;
    endfunction

    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            cmp_e = exp_q.pop_front();
            chk1("le_ready", le_ready, cmp_e.ready);
            chk1("be_ready", be_ready, cmp_e.ready);
            chk1("le_rd", le_rd, cmp_e.rd);
            chk1("be_rd", be_rd, cmp_e.rd);
            chk1("le_wr", le_wr, cmp_e.wr);
            chk1("be_wr", be_wr, cmp_e.wr);
            chk1("le_done", le_done, cmp_e.done);
            chk1("be_done", be_done, cmp_e.done);
            chk1("le_err", le_err, cmp_e.err);
            chk1("be_err", be_err, cmp_e.err);
            if (cmp_e.rd || cmp_e.wr) begin
                chk32("le_addr", le_addr, cmp_e.addr);
                chk32("be_addr", be_addr, cmp_e.addr);
            end
            if (cmp_e.wr) begin
                chk32("le_wdata", le_wdata, cmp_e.wd_le);
                chk32("be_wdata", be_wdata, cmp_e.wd_be);
            end
        end
    end

    task automatic idle_cycle();
        @(negedge clk);
        req_valid = 1'b0;
        mem_ack   = 1'($urandom_range(0, 1));
        mem_rdata = $urandom;
        exp_q.push_back(idle_e());
    endtask

    // One store: build the expected per-cycle outputs from the latency rules
    // (rs/ws = cycles the memory stalls before acking), then drive it.
    task automatic run_store(input logic [31:0] addr, input logic [1:0] size,
                             input logic [31:0] data, input logic [31:0] rdata,
                             input int rs, input int ws, input bit toggle);
        exp_t        ph[$];
        bit          ak[$];
        exp_t        e;
        bit          rej;
        logic [31:0] wa;
        wa  = addr & 32'hFFFF_FFFC;
        rej = (size == 2'b11) || (size == 2'b01 && addr[0]) ||
              (size == 2'b10 && addr[1:0] != 2'b00);
        if (!rej) begin
            if (size != 2'b10) begin
                for (int i = 0; i <= rs; i++) begin
                    e = '0; e.rd = 1'b1; e.addr = wa;
                    ph.push_back(e); ak.push_back(i == rs);
                end
            end
            for (int i = 0; i <= ws; i++) begin
                e = '0; e.wr = 1'b1; e.addr = wa;
                e.wd_le = model_merge(rdata, data, size, addr[1:0], 1'b0);
                e.wd_be = model_merge(rdata, data, size, addr[1:0], 1'b1);
                ph.push_back(e); ak.push_back(i == ws);
            end
        end
        e = '0; e.done = 1'b1; e.err = rej;
        ph.push_back(e); ak.push_back(1'($urandom_range(0, 1)));

        @(negedge clk);
        req_valid = 1'b1;
        req_addr  = addr;
        req_data  = data;
        req_size  = size;
        mem_ack   = 1'($urandom_range(0, 1));
        mem_rdata = $urandom;
        exp_q.push_back(ph[0]);
        for (int j = 0; j < ph.size(); j++) begin
            @(negedge clk);
            req_valid = toggle ? 1'($urandom_range(0, 1)) : 1'b0;
            req_addr  = $urandom;
            req_data  = $urandom;
            req_size  = 2'($urandom_range(0, 3));
            mem_ack   = ak[j];
            mem_rdata = ak[j] ? rdata : $urandom;
            exp_q.push_back((j + 1 < ph.size()) ? ph[j + 1] : idle_e());
        end
    endtask

    task automatic reset_mid_write();
        exp_t e;
        e = '0; e.wr = 1'b1; e.addr = 32'h0000_5000;
        e.wd_le = 32'h0BAD_F00D; e.wd_be = 32'h0BAD_F00D;
        @(negedge clk);
        req_valid = 1'b1; req_addr = 32'h0000_5000; req_data = 32'h0BAD_F00D;
        req_size = 2'b10; mem_ack = 1'b0;
        exp_q.push_back(e);
        repeat (2) begin
            @(negedge clk);
            req_valid = 1'b0; mem_ack = 1'b0;
            exp_q.push_back(e);
        end
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk1("rstw_le_wr", le_wr, 1'b0);
        chk1("rstw_be_wr", be_wr, 1'b0);
        chk1("rstw_ready", le_ready, 1'b1);
        chk1("rstw_done", le_done, 1'b0);
        exp_q.delete();
        repeat (2) begin
            @(posedge clk);
            #1;
            chk1("rstw_hold_done", le_done | be_done, 1'b0);
            chk1("rstw_hold_wr", le_wr | be_wr, 1'b0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.push_back(idle_e());
    endtask

    initial begin
        logic [31:0] a;
        logic [1:0]  sz;
        rst_n = 1'b1; req_valid = 1'b0; req_addr = '0; req_data = '0;
        req_size = '0; mem_ack = 1'b0; mem_rdata = '0;
        #2 rst_n = 1'b0;
        #1;
        chk1("rst_ready", le_ready & be_ready, 1'b1);
        chk1("rst_done", le_done | be_done, 1'b0);
        chk1("rst_err", le_err | be_err, 1'b0);
        chk1("rst_rd", le_rd | be_rd, 1'b0);
        chk1("rst_wr", le_wr | be_wr, 1'b0);
        chk32("rst_addr", le_addr | be_addr, 32'h0);
        chk32("rst_wdata", le_wdata | be_wdata, 32'h0);

        chk32("pin_le_byte", model_merge(32'h11223344, 32'hAABBCCDD, 2'b00, 2'd2, 1'b0), 32'h11DD3344);
        chk32("pin_be_byte", model_merge(32'h11223344, 32'hAABBCCDD, 2'b00, 2'd2, 1'b1), 32'h1122DD44);
        chk32("pin_le_half", model_merge(32'hFFFFFFFF, 32'h0000BEEF, 2'b01, 2'd2, 1'b0), 32'hBEEFFFFF);
        chk32("pin_be_half", model_merge(32'hFFFFFFFF, 32'h0000BEEF, 2'b01, 2'd2, 1'b1), 32'hFFFFBEEF);

        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.push_back(idle_e());

        run_store(32'h0000_1002, 2'b00, 32'hAABBCCDD, 32'h11223344, 1, 1, 1'b0);
        run_store(32'h0000_2002, 2'b01, 32'h0000BEEF, 32'hFFFFFFFF, 1, 1, 1'b0);
        run_store(32'h0000_3000, 2'b10, 32'hCAFEF00D, 32'h0, 1, 1, 1'b0);
        run_store(32'h0000_4001, 2'b01, 32'h12345678, 32'h0, 1, 1, 1'b0);
        run_store(32'h0000_4002, 2'b10, 32'h12345678, 32'h0, 1, 1, 1'b0);
        run_store(32'h0000_4000, 2'b11, 32'h12345678, 32'h0, 1, 1, 1'b0);
        run_store(32'h0000_6001, 2'b00, 32'h000000A5, 32'h01234567, 5, 1, 1'b1);
        idle_cycle();
        reset_mid_write();
        run_store(32'h0000_7003, 2'b00, 32'h12345678, 32'hA5A5A5A5, 1, 1, 1'b0);

        for (int t = 0; t < 60; t++) begin
            a  = $urandom;
            sz = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 3) != 0) begin
                if (sz == 2'b10) a[1:0] = 2'b00;
                if (sz == 2'b01) a[0] = 1'b0;
            end
            if ($urandom_range(0, 2) == 0) idle_cycle();
            run_store(a, sz, $urandom, $urandom, $urandom_range(0, 3), $urandom_range(0, 3),
                      1'($urandom_range(0, 1)));
        end

        idle_cycle();
        idle_cycle();
        @(posedge clk);
        #3;
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
